// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 S-box memory and its storage array.
package rc4_pkg;

    typedef enum logic [1:0] {IDLE, SWAP, INIT} sbox_state_t;

    localparam int SBOX_DEPTH = 256;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/rc4_sbox_regfile.sv
// 256-entry byte array holding the S-box permutation: two combinational read
// ports, two synchronous write ports and a synchronous identity reset.
module rc4_sbox_regfile
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_ra_addr,
    output logic [7:0] o_ra_data,
    input  logic [7:0] i_rb_addr,
    output logic [7:0] o_rb_data,
    input  logic       i_wa_en,
    input  logic [7:0] i_wa_addr,
    input  logic [7:0] i_wa_data,
    input  logic       i_wb_en,
    input  logic [7:0] i_wb_addr,
    input  logic [7:0] i_wb_data
);

    byte_t r_mem [SBOX_DEPTH];

    // Storage update: identity on reset, otherwise port A then port B so B wins on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < SBOX_DEPTH; n++) begin
                r_mem[n] <= byte_t'(n);
            end
        end else begin
            if (i_wa_en) begin
                r_mem[i_wa_addr] <= i_wa_data;
            end
            if (i_wb_en) begin
                r_mem[i_wb_addr] <= i_wb_data;
            end
        end
    end

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];

endmodule

// File: rtl/rc4_sbox_mem.sv
// RC4 S-box responder: byte read/write, i/j swap and identity-fill sequencing
// around the rc4_sbox_regfile storage array.
module rc4_sbox_mem
    import rc4_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    input  logic                     read_enable_i,
    output logic [DW-1:0]            rdata_o,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     write_enable_i,
    input  logic                     swap_i,
    input  logic                     init_start_i,
    output logic                     busy_o,
    output logic                     swap_done_o,
    output logic                     init_done_o
);

    sbox_state_t r_state;
    sbox_state_t w_state_nxt;
    byte_t       r_k;
    byte_t       w_k_nxt;
    byte_t       r_i;
    byte_t       r_j;
    byte_t       r_a;
    byte_t       r_b;
    logic        w_capture;

    logic        w_wa_en;
    byte_t       w_wa_addr;
    byte_t       w_wa_data;
    logic        w_wb_en;
    byte_t       w_wb_addr;
    byte_t       w_wb_data;
    byte_t       w_ra_data;
    byte_t       w_rb_data;

    rc4_sbox_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_ra_addr (waddr_i),
        .o_ra_data (w_ra_data),
        .i_rb_addr (raddr_i),
        .o_rb_data (w_rb_data),
        .i_wa_en   (w_wa_en),
        .i_wa_addr (w_wa_addr),
        .i_wa_data (w_wa_data),
        .i_wb_en   (w_wb_en),
        .i_wb_addr (w_wb_addr),
        .i_wb_data (w_wb_data)
    );

    // State, fill counter and swap operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= 8'd0;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            if (w_capture) begin
                r_i <= waddr_i;
                r_j <= raddr_i;
                r_a <= w_ra_data;
                r_b <= w_rb_data;
            end
        end
    end

    // Next-state and write-port steering; requests are only accepted in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_capture   = 1'b0;
        w_wa_en     = 1'b0;
        w_wa_addr   = waddr_i;
        w_wa_data   = wdata_i;
        w_wb_en     = 1'b0;
        w_wb_addr   = r_j;
        w_wb_data   = r_a;
        case (r_state)
            IDLE: begin
                if (init_start_i) begin
                    w_state_nxt = INIT;
                    w_k_nxt     = 8'd0;
                end else if (swap_i) begin
                    w_state_nxt = SWAP;
                    w_capture   = 1'b1;
                end else if (write_enable_i) begin
                    w_wa_en = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SWAP: begin
                w_wa_en     = 1'b1;
                w_wa_addr   = r_i;
                w_wa_data   = r_b;
                w_wb_en     = 1'b1;
                w_state_nxt = IDLE;
            end
            INIT: begin
                w_wa_en   = 1'b1;
                w_wa_addr = r_k;
                w_wa_data = r_k;
                w_k_nxt   = r_k + 8'd1;
                if (r_k == 8'hFF) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = INIT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rdata_o     = read_enable_i ? w_rb_data : 8'h00;
    assign busy_o      = (r_state != IDLE);
    assign swap_done_o = (r_state == SWAP);
    assign init_done_o = (r_state == INIT) && (r_k == 8'hFF);

endmodule

// File: tb/tb_rc4_sbox_mem.sv
// Self-checking bench for rc4_sbox_mem: directed cases plus randomized
// read/write/swap traffic checked against an array model of the S-box.
module tb_rc4_sbox_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raddr_i;
    logic       read_enable_i;
    logic [7:0] rdata_o;
    logic [7:0] waddr_i;
    logic [7:0] wdata_i;
    logic       write_enable_i;
    logic       swap_i;
    logic       init_start_i;
    logic       busy_o;
    logic       swap_done_o;
    logic       init_done_o;

    logic [7:0] m_s [256];
    int n_checks = 0;
    int n_fail   = 0;

    rc4_sbox_mem dut (
        .clk            (clk),
        .rst            (rst),
        .raddr_i        (raddr_i),
        .read_enable_i  (read_enable_i),
        .rdata_o        (rdata_o),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .write_enable_i (write_enable_i),
        .swap_i         (swap_i),
        .init_start_i   (init_start_i),
        .busy_o         (busy_o),
        .swap_done_o    (swap_done_o),
        .init_done_o    (init_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_identity();
        for (int k = 0; k < 256; k++) m_s[k] = 8'(k);
    endtask

    task automatic quiet();
        write_enable_i = 1'b0;
        swap_i         = 1'b0;
        init_start_i   = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            raddr_i = 8'(k);
            read_enable_i = 1'b1;
            #1;
            chk(tag, rdata_o, m_s[k]);
        end
        chk({tag, "_busy"}, busy_o, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] a);
        @(negedge clk);
        raddr_i = a;
        read_enable_i = 1'b1;
        #1;
        chk("rd", rdata_o, m_s[a]);
        read_enable_i = 1'b0;
        #1;
        chk("rd_off", rdata_o, 8'h00);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        waddr_i = a; wdata_i = d; write_enable_i = 1'b1;
        raddr_i = a; read_enable_i = 1'b1;
        #1;
        chk("wr_same_cycle", rdata_o, m_s[a]);
        @(negedge clk);
        write_enable_i = 1'b0;
        m_s[a] = d;
        #1;
        chk("wr_next_cycle", rdata_o, d);
    endtask

    // hold=1 keeps swap_i (and a junk write) asserted through the busy cycle.
    task automatic do_swap(input logic [7:0] i, input logic [7:0] j, input bit hold);
        logic [7:0] t;
        @(negedge clk);
        waddr_i = i; raddr_i = j; swap_i = 1'b1; read_enable_i = 1'b1;
        #1;
        chk("sw_req_busy", busy_o, 1'b0);
        @(negedge clk);
        #1;
        chk("sw_busy", busy_o, 1'b1);
        chk("sw_done", swap_done_o, 1'b1);
        chk("sw_old_j", rdata_o, m_s[j]);
        if (hold) begin
            wdata_i = ~m_s[i];
            write_enable_i = 1'b1;
        end else begin
            swap_i = 1'b0;
        end
        @(negedge clk);
        quiet();
        t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
        #1;
        chk("sw_done_end", swap_done_o, 1'b0);
        chk("sw_idle", busy_o, 1'b0);
        chk("sw_new_j", rdata_o, m_s[j]);
        raddr_i = i;
        #1;
        chk("sw_new_i", rdata_o, m_s[i]);
        @(negedge clk);
        #1;
        chk("sw_no_rerun", busy_o, 1'b0);
    endtask

    // Starts a fill; with prio=1 also raises swap/write to confirm they are dropped.
    task automatic do_init(input bit prio);
        logic [7:0] old5;
        old5 = m_s[5];
        @(negedge clk);
        init_start_i = 1'b1;
        if (prio) begin
            swap_i = 1'b1; write_enable_i = 1'b1;
            waddr_i = 8'd5; wdata_i = ~old5; raddr_i = 8'd9;
        end
        for (int n = 1; n <= 256; n++) begin
            @(negedge clk);
            quiet();
            raddr_i = 8'd5; read_enable_i = 1'b1;
            #1;
            chk("init_done", init_done_o, (n == 256) ? 1'b1 : 1'b0);
            chk("init_busy", busy_o, 1'b1);
            if (prio && n <= 2) chk("prio_s5", rdata_o, old5);
        end
        @(negedge clk);
        #1;
        chk("init_end_busy", busy_o, 1'b0);
        chk("init_end_done", init_done_o, 1'b0);
        model_identity();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        raddr_i = 8'd0; read_enable_i = 1'b0; waddr_i = 8'd0; wdata_i = 8'd0;
        quiet();
        model_identity();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_sdone", swap_done_o, 1'b0);
        chk("rst_idone", init_done_o, 1'b0);
        rst = 1'b0;
        sweep("rst_sweep");

        do_write(8'h10, 8'hA5);
        do_swap(8'd3, 8'd200, 1'b1);
        do_swap(8'd7, 8'd7, 1'b0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 2))
                0: do_write(8'($urandom), 8'($urandom));
                1: do_swap(8'($urandom), 8'($urandom), 1'($urandom));
                default: do_read(8'($urandom));
            endcase
        end

        do_write(8'd5, 8'h5A);
        do_write(8'd9, 8'hC3);
        do_init(1'b1);
        sweep("prio_sweep");

        for (int n = 0; n < 20; n++) do_write(8'($urandom), 8'($urandom));
        @(negedge clk);
        init_start_i = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            quiet();
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_identity();
        #1;
        chk("rstfill_busy", busy_o, 1'b0);
        chk("rstfill_done", init_done_o, 1'b0);
        sweep("rstfill_sweep");
        chk("rstfill_done_late", init_done_o, 1'b0);

        @(negedge clk);
        waddr_i = 8'd1; raddr_i = 8'd2; swap_i = 1'b1;
        @(negedge clk);
        #1;
        chk("rstswap_busy", busy_o, 1'b1);
        swap_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstswap_idle", busy_o, 1'b0);
        do_read(8'd1);
        do_read(8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
